// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU's multi-cycle arithmetic unit.
//   state_e    : divider control states (IDLE, ITER, DONE)
//   WIDTH_DEF  : default operand/result width in bits
//   cnt_width  : width of an iteration counter that must hold the value w
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must represent the full iteration count (w), not just w-1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/alu_sub_borrow.sv
// -----------------------------------------------------------------------------
// alu_sub_borrow
// Combinational unsigned subtractor with an explicit borrow flag, used by the
// divider for its trial subtraction. Borrow is 1 exactly when i_a < i_b.
//   i_a      in  N  minuend
//   i_b      in  N  subtrahend
//   o_diff   out N  i_a - i_b (modulo 2**N)
//   o_borrow out 1  1 when the subtraction underflowed
// -----------------------------------------------------------------------------
module alu_sub_borrow #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    // Zero-extending both operands by one bit makes the extra result bit the
    // borrow: it is set only when the true difference is negative.
    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/alu_div_4b.sv
// -----------------------------------------------------------------------------
// alu_div_4b
// Sequential restoring divider: one shift-and-trial-subtract per clock.
// Unsigned dividend/divisor are captured on an accepted start; quotient and
// remainder are returned with a single-cycle done pulse and held until the
// next accepted start. Division by zero completes in one cycle with
// quotient = all ones, remainder = dividend and div_zero set.
//   i_clk        in  1      rising-edge clock
//   i_rst        in  1      asynchronous active-low reset
//   i_start      in  1      request, sampled only in IDLE
//   i_dividend   in  WIDTH  unsigned numerator
//   i_divisor    in  WIDTH  unsigned denominator
//   o_busy       out 1      high while iterating
//   o_done       out 1      one-cycle pulse, results valid
//   o_quotient   out WIDTH  quotient
//   o_remainder  out WIDTH  remainder
//   o_div_zero   out 1      divisor was zero (held with results)
// -----------------------------------------------------------------------------
module alu_div_4b
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   w_r_nxt;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   w_d_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_div_zero;
    logic               w_div_zero_nxt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_trial;
    logic               w_borrow;
    logic               w_unused_trial_msb;

    // Partial remainder with the next dividend bit brought in from the top of
    // the quotient register.
    assign w_shifted = {r_r, r_q[WIDTH-1]};

    alu_sub_borrow #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a      (w_shifted),
        .i_b      ({1'b0, r_d}),
        .o_diff   (w_trial),
        .o_borrow (w_borrow)
    );

    // The partial remainder is always below the divisor, so a successful
    // trial never sets the top bit; only the low WIDTH bits are kept.
    assign w_unused_trial_msb = w_trial[WIDTH];

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_q_nxt        = r_q;
        w_r_nxt        = r_r;
        w_d_nxt        = r_d;
        w_count_nxt    = r_count;
        w_div_zero_nxt = r_div_zero;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_d_nxt = i_divisor;
                    if (i_divisor == '0) begin
                        w_q_nxt        = '1;
                        w_r_nxt        = i_dividend;
                        w_count_nxt    = '0;
                        w_div_zero_nxt = 1'b1;
                        w_state_nxt    = DONE;
                    end else begin
                        w_q_nxt        = i_dividend;
                        w_r_nxt        = '0;
                        w_count_nxt    = CNT_W'(WIDTH);
                        w_div_zero_nxt = 1'b0;
                        w_state_nxt    = ITER;
                    end
                end
            end

            ITER: begin
                // Restoring step: keep the trial difference only if it did
                // not borrow; the quotient bit records that outcome.
                w_q_nxt     = {r_q[WIDTH-2:0], ~w_borrow};
                w_r_nxt     = w_borrow ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
                w_count_nxt = r_count - CNT_W'(1);
                if (r_count == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_q        <= '0;
            r_r        <= '0;
            r_d        <= '0;
            r_count    <= '0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_q        <= w_q_nxt;
            r_r        <= w_r_nxt;
            r_d        <= w_d_nxt;
            r_count    <= w_count_nxt;
            r_div_zero <= w_div_zero_nxt;
            // Status flags are flopped from the next state so they line up
            // with the state register and drive the ports glitch-free.
            r_busy     <= (w_state_nxt == ITER);
            r_done     <= (w_state_nxt == DONE);
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_quotient  = r_q;
    assign o_remainder = r_r;
    assign o_div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_div_4b.sv
// -----------------------------------------------------------------------------
// tb_alu_div_4b
// Directed, table-driven bench for the 4-bit restoring divider, plus
// hand-written sequences for reset, start-during-ITER and mid-ITER reset.
// -----------------------------------------------------------------------------
module tb_alu_div_4b;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_div_4b #(.WIDTH(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .o_busy      (busy),
        .o_done      (done),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_div_zero  (div_zero)
    );

    typedef struct {
        logic [3:0] dvd;
        logic [3:0] dvs;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called on a falling edge; start is seen by the next rising edge (E0).
    // Optionally pulses start with other operands while iterating.
    task automatic run_op(input logic [3:0] dvd, input logic [3:0] dvs,
                          input logic [3:0] q, input logic [3:0] r,
                          input logic dz, input bit inject);
        int    k;
        int    busy_cnt;
        string tag;
        tag      = $sformatf("%0d/%0d", dvd, dvs);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~dvd;
        divisor  = ~dvs;
        k        = 0;
        busy_cnt = 0;
        while (!done && k < 40) begin
            busy_cnt += int'(busy);
            if (inject && k == 1) begin
                start    = 1'b1;
                dividend = 4'd15;
                divisor  = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, " latency"},  k,        dz ? 0 : 4);
        check({tag, " busy_cyc"}, busy_cnt, dz ? 0 : 4);
        check({tag, " busy@done"}, busy,    1'b0);
        check({tag, " quotient"},  quotient,  q);
        check({tag, " remainder"}, remainder, r);
        check({tag, " div_zero"},  div_zero,  dz);
        @(negedge clk);
        check({tag, " done_pulse"}, done,     1'b0);
        check({tag, " q_held"},     quotient,  q);
        check({tag, " r_held"},     remainder, r);
        check({tag, " dz_held"},    div_zero,  dz);
    endtask

    initial begin
        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
        vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[2] = '{4'd2,  4'd9,  4'd0,  4'd2, 1'b0};
        vecs[3] = '{4'd7,  4'd0,  4'hF,  4'd7, 1'b1};
        vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[6] = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0};
        vecs[7] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0};
        vecs[8] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1};
        vecs[9] = '{4'd8,  4'd3,  4'd2,  4'd2, 1'b0};

        // Reset held with start asserted: nothing may happen.
        rst      = 1'b0;
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        repeat (3) @(negedge clk);
        check("rst busy",      busy,      1'b0);
        check("rst done",      done,      1'b0);
        check("rst quotient",  quotient,  4'd0);
        check("rst remainder", remainder, 4'd0);
        check("rst div_zero",  div_zero,  1'b0);
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle busy",     busy,      1'b0);
        check("idle done",     done,      1'b0);
        check("idle quotient", quotient,  4'd0);

        // Back-to-back table vectors, each started at the first legal edge.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);
        end

        // start pulsed mid-iteration with other operands must be ignored.
        run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);

        // Reset dropped during the second iteration of 13/3.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst busy",      busy,      1'b0);
        check("midrst done",      done,      1'b0);
        check("midrst quotient",  quotient,  4'd0);
        check("midrst remainder", remainder, 4'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst no_done", done, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("post_rst no_done", done, 1'b0);
        run_op(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
